// File: rtl/tb_decode_pkg.sv
// Shared types for the decode-stream collector and its matching bench-side driver.
package tb_decode_pkg;
    localparam int WORD_W = 32;

    typedef enum logic {FILL, HOLD} collector_state_t;

    typedef logic [WORD_W-1:0] inst_word_t;
endpackage

// File: rtl/tb_sat_counter.sv
// Saturating event counter with a synchronous clear; holds at all-ones.
module tb_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;
endmodule

// File: rtl/tb_decode_collector.sv
// Packs 32-bit instruction words into WIDTH-bit bundles (lowest word first) for the scoreboard.
// Optional statistics counters are enabled with TB_DECODE_COLLECTOR_STATS_EN.
module tb_decode_collector
    import tb_decode_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic                                clk,
    input  logic                                reset,
    input  inst_word_t                          inst_in,
    input  logic                                inst_valid,
    output logic                                inst_ready,
    input  logic                                flush,
    output logic [WIDTH-1:0]                    bundle_out,
    output logic [$clog2(WIDTH/WORD_W+1)-1:0]   bundle_words,
    output logic                                bundle_valid,
    input  logic                                bundle_ready
`ifdef TB_DECODE_COLLECTOR_STATS_EN
    ,
    output logic [31:0]                         stat_bundles,
    output logic [31:0]                         stat_stalls
`endif
);
    localparam int WORDS = WIDTH / WORD_W;
    localparam int CW    = $clog2(WORDS + 1);

    if ((WIDTH < WORD_W) || ((WIDTH % WORD_W) != 0)) begin : g_bad_width
        $error("tb_decode_collector: WIDTH must be a multiple of 32 and >= 32");
    end

    collector_state_t state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    bwords_q, bwords_d;
    logic [WIDTH-1:0] bundle_q, bundle_d;
    logic             take;

    // Handshake outputs depend only on registered state (plus the reset gate).
    assign inst_ready   = reset && (state_q == FILL);
    assign bundle_valid = (state_q == HOLD);
    assign take         = inst_valid && inst_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bwords_d = bwords_q;
        bundle_d = bundle_q;
        case (state_q)
            FILL: begin
                if (take) begin
                    for (int i = 0; i < WORDS; i++) begin
                        if (cnt_q == CW'(i)) begin
                            bundle_d[i*WORD_W +: WORD_W] = inst_in;
                        end
                    end
                    cnt_d = cnt_q + CW'(1);
                end
                // A flush arriving with a word closes the bundle after capturing that word.
                if (take && (cnt_q == CW'(WORDS - 1))) begin
                    state_d  = HOLD;
                    bwords_d = CW'(WORDS);
                end else if (take && flush) begin
                    state_d  = HOLD;
                    bwords_d = cnt_q + CW'(1);
                end else if (flush && (cnt_q != '0)) begin
                    state_d  = HOLD;
                    bwords_d = cnt_q;
                end
            end
            HOLD: begin
                if (bundle_ready) begin
                    state_d  = FILL;
                    cnt_d    = '0;
                    bwords_d = '0;
                    bundle_d = '0;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= FILL;
            cnt_q    <= '0;
            bwords_q <= '0;
            bundle_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bwords_q <= bwords_d;
            bundle_q <= bundle_d;
        end
    end

    assign bundle_out   = bundle_q;
    assign bundle_words = bwords_q;

`ifdef TB_DECODE_COLLECTOR_STATS_EN
    tb_sat_counter #(.W(32)) u_stat_bundles (
        .clk   (clk),
        .clear (!reset),
        .inc   (bundle_valid && bundle_ready),
        .count (stat_bundles)
    );

    tb_sat_counter #(.W(32)) u_stat_stalls (
        .clk   (clk),
        .clear (!reset),
        .inc   (bundle_valid && !bundle_ready),
        .count (stat_stalls)
    );
`endif
endmodule

// File: tb/tb_tb_decode_collector.sv
// Randomised self-checking bench: three collectors (WIDTH 32/64/128) share one input stream
// and are each checked against a word-list reference model.
module tb_tb_decode_collector;
    localparam int NW[3] = '{1, 2, 4};

    logic        clk = 1'b0;
    logic        r_reset = 1'b0;
    logic [31:0] r_inst = '0;
    logic        r_valid = 1'b0;
    logic        r_flush = 1'b0;
    logic        r_bready = 1'b0;

    logic         ready32, ready64, ready128;
    logic         valid32, valid64, valid128;
    logic [31:0]  out32;
    logic [63:0]  out64;
    logic [127:0] out128;
    logic [0:0]   words32;
    logic [1:0]   words64;
    logic [2:0]   words128;

    logic [127:0] obs_out[3];
    logic [2:0]   obs_words[3];
    logic         obs_ready[3];
    logic         obs_valid[3];

    int errors = 0;
    int checks = 0;

    logic [31:0] m_slot[3][4];
    int          m_cnt[3];
    int          m_words[3];
    bit          m_hold[3];
    int          m_bund[3];
    int          m_stall[3];

    always #5 clk = ~clk;

`ifdef TB_DECODE_COLLECTOR_STATS_EN
    logic [31:0] sb32, sb64, sb128, ss32, ss64, ss128;
    logic [31:0] obs_sb[3];
    logic [31:0] obs_ss[3];
    assign obs_sb[0] = sb32;  assign obs_sb[1] = sb64;  assign obs_sb[2] = sb128;
    assign obs_ss[0] = ss32;  assign obs_ss[1] = ss64;  assign obs_ss[2] = ss128;
`endif

    tb_decode_collector #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(r_reset), .inst_in(r_inst), .inst_valid(r_valid), .inst_ready(ready32),
        .flush(r_flush), .bundle_out(out32), .bundle_words(words32), .bundle_valid(valid32),
        .bundle_ready(r_bready)
`ifdef TB_DECODE_COLLECTOR_STATS_EN
        , .stat_bundles(sb32), .stat_stalls(ss32)
`endif
    );

    tb_decode_collector #(.WIDTH(64)) dut64 (
        .clk(clk), .reset(r_reset), .inst_in(r_inst), .inst_valid(r_valid), .inst_ready(ready64),
        .flush(r_flush), .bundle_out(out64), .bundle_words(words64), .bundle_valid(valid64),
        .bundle_ready(r_bready)
`ifdef TB_DECODE_COLLECTOR_STATS_EN
        , .stat_bundles(sb64), .stat_stalls(ss64)
`endif
    );

    tb_decode_collector #(.WIDTH(128)) dut128 (
        .clk(clk), .reset(r_reset), .inst_in(r_inst), .inst_valid(r_valid), .inst_ready(ready128),
        .flush(r_flush), .bundle_out(out128), .bundle_words(words128), .bundle_valid(valid128),
        .bundle_ready(r_bready)
`ifdef TB_DECODE_COLLECTOR_STATS_EN
        , .stat_bundles(sb128), .stat_stalls(ss128)
`endif
    );

    assign obs_out[0] = {96'b0, out32};
    assign obs_out[1] = {64'b0, out64};
    assign obs_out[2] = out128;
    assign obs_words[0] = {2'b0, words32};
    assign obs_words[1] = {1'b0, words64};
    assign obs_words[2] = words128;
    assign obs_ready[0] = ready32;  assign obs_ready[1] = ready64;  assign obs_ready[2] = ready128;
    assign obs_valid[0] = valid32;  assign obs_valid[1] = valid64;  assign obs_valid[2] = valid128;

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [127:0] expectedBundle(input int d);
        logic [127:0] v = '0;
        for (int i = 0; i < m_words[d]; i++) begin
            v = v | (128'(m_slot[d][i]) << (32 * i));
        end
        return v;
    endfunction

    task automatic clearModel(input int d);
        m_hold[d]  = 1'b0;
        m_cnt[d]   = 0;
        m_words[d] = 0;
        for (int i = 0; i < 4; i++) m_slot[d][i] = '0;
    endtask

    // Reference: a list of collected words that closes when full or flushed.
    task automatic updateModels();
        for (int d = 0; d < 3; d++) begin
            if (!r_reset) begin
                clearModel(d);
                m_bund[d]  = 0;
                m_stall[d] = 0;
            end else if (m_hold[d]) begin
                if (r_bready) begin
                    m_bund[d]++;
                    clearModel(d);
                end else begin
                    m_stall[d]++;
                end
            end else begin
                if (r_valid) begin
                    m_slot[d][m_cnt[d]] = r_inst;
                    m_cnt[d]++;
                end
                if ((r_valid && m_cnt[d] == NW[d]) || (r_flush && m_cnt[d] > 0)) begin
                    m_hold[d]  = 1'b1;
                    m_words[d] = m_cnt[d];
                end
            end
        end
    endtask

    task automatic compareAll();
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("w%0d_inst_ready", NW[d] * 32), 128'(obs_ready[d]),
                        128'(r_reset && !m_hold[d]));
            checkOutput($sformatf("w%0d_bundle_valid", NW[d] * 32), 128'(obs_valid[d]), 128'(m_hold[d]));
            if (m_hold[d]) begin
                checkOutput($sformatf("w%0d_bundle_out", NW[d] * 32), obs_out[d], expectedBundle(d));
                checkOutput($sformatf("w%0d_bundle_words", NW[d] * 32), 128'(obs_words[d]), 128'(m_words[d]));
            end
`ifdef TB_DECODE_COLLECTOR_STATS_EN
            checkOutput($sformatf("w%0d_stat_bundles", NW[d] * 32), 128'(obs_sb[d]), 128'(m_bund[d]));
            checkOutput($sformatf("w%0d_stat_stalls", NW[d] * 32), 128'(obs_ss[d]), 128'(m_stall[d]));
`endif
        end
    endtask

    // Drive one cycle of inputs, compare against the model, then advance the model at the edge.
    task automatic applyStimulus(input logic rst, input logic valid, input logic [31:0] inst,
                                 input logic fl, input logic bready);
        r_reset  = rst;
        r_valid  = valid;
        r_inst   = inst;
        r_flush  = fl;
        r_bready = bready;
        #1;
        compareAll();
        @(posedge clk);
        updateModels();
        #1;
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            clearModel(d);
            m_bund[d]  = 0;
            m_stall[d] = 0;
        end
        @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
        checkOutput("rst_inst_ready", 128'(ready64), 128'(0));
        checkOutput("rst_bundle_valid", 128'(valid64), 128'(0));
        checkOutput("rst_bundle_out", obs_out[2], 128'(0));

        applyStimulus(1'b1, 1'b1, 32'hAAAA_0001, 1'b0, 1'b1);
        checkOutput("w32_direct_valid", 128'(valid32), 128'(1));
        checkOutput("w32_direct_words", 128'(words32), 128'(1));
        checkOutput("w32_direct_out", 128'(out32), 128'h0000_0000_0000_0000_0000_0000_AAAA_0001);
        applyStimulus(1'b1, 1'b1, 32'hBBBB_0002, 1'b0, 1'b1);
        checkOutput("pair_valid", 128'(valid64), 128'(1));
        checkOutput("pair_out", 128'(out64), 128'h0000_0000_0000_0000_BBBB_0002_AAAA_0001);
        checkOutput("pair_words", 128'(words64), 128'(2));
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("pair_valid_one_cycle", 128'(valid64), 128'(0));

        applyStimulus(1'b1, 1'b1, 32'h0000_0011, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h0000_0022, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, $urandom, 1'b0, 1'b0);
            checkOutput("bp_inst_ready", 128'(ready64), 128'(0));
            checkOutput("bp_stable", 128'(out64), 128'h0000_0000_0000_0000_0000_0022_0000_0011);
        end
`ifdef TB_DECODE_COLLECTOR_STATS_EN
        checkOutput("bp_stat_stalls", 128'(ss64), 128'(5));
`endif
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);

        applyStimulus(1'b1, 1'b1, 32'h1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h2, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("flush_valid", 128'(valid128), 128'(1));
        checkOutput("flush_out", out128, 128'h0000_0000_0000_0000_0000_0002_0000_0001);
        checkOutput("flush_words", 128'(words128), 128'(2));
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);

        applyStimulus(1'b1, 1'b1, 32'h1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h2, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h3, 1'b1, 1'b1);
        checkOutput("flush_conc_words", 128'(words128), 128'(3));
        checkOutput("flush_conc_out", out128, 128'h0000_0000_0000_0003_0000_0002_0000_0001);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("flush_empty_w32", 128'(valid32), 128'(0));
        checkOutput("flush_empty_w64", 128'(valid64), 128'(0));
        checkOutput("flush_empty_w128", 128'(valid128), 128'(0));

        applyStimulus(1'b1, 1'b1, 32'hDEAD_0001, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'hDEAD_0002, 1'b0, 1'b0);
        checkOutput("hold_before_rst", 128'(valid64), 128'(1));
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("rst_hold_valid", 128'(valid64), 128'(0));
        checkOutput("rst_hold_out", 128'(out64), 128'(0));
        applyStimulus(1'b1, 1'b1, 32'h5, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h6, 1'b0, 1'b0);
        checkOutput("post_rst_out", 128'(out64), 128'h0000_0000_0000_0000_0000_0006_0000_0005);
        checkOutput("post_rst_words", 128'(words64), 128'(2));
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(49) != 0), ($urandom_range(3) != 0), $urandom,
                          ($urandom_range(3) == 0), $urandom_range(1));
        end
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
